// File: rtl/uart_parity_engine.sv
// rtl/uart_parity_engine.sv - registered UART parity generator (TX) and checker (RX) with saturating error count
module uart_parity_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Par_en,
    input  logic [1:0]            Par_mode,
    input  logic                  Data_valid,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  Ser_busy,
    output logic                  Par_bit,
    output logic                  Par_ready,
    input  logic                  Rx_valid,
    input  logic [DATA_WIDTH-1:0] Rx_Data,
    input  logic                  Rx_par,
    output logic                  Par_err,
    output logic                  Chk_done,
    input  logic                  Err_clr,
    output logic [CNT_WIDTH-1:0]  Err_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        FRAME  = 2'd2
    } tx_state_e;

    tx_state_e             state_q, state_d;
    logic                  par_bit_q, par_bit_d;
    logic                  par_ready_q, par_ready_d;
    logic                  par_err_q, par_err_d;
    logic                  chk_done_q, chk_done_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_base;

    // mode: 00 even, 01 odd, 10 mark, 11 space
    function automatic logic parity_f(input logic [DATA_WIDTH-1:0] d, input logic [1:0] mode);
        case (mode)
            2'b00:   parity_f = ^d;
            2'b01:   parity_f = ~^d;
            2'b10:   parity_f = 1'b1;
            default: parity_f = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        par_bit_d   = par_bit_q;
        par_ready_d = par_ready_q;
        case (state_q)
            IDLE: begin
                if (Data_valid) begin
                    par_bit_d   = Par_en & parity_f(P_Data, Par_mode);
                    par_ready_d = 1'b1;
                    state_d     = LOADED;
                end
            end
            LOADED: begin
                // Frame start wins over a simultaneous reload
                if (Ser_busy) begin
                    state_d = FRAME;
                end else if (Data_valid) begin
                    par_bit_d = Par_en & parity_f(P_Data, Par_mode);
                end
            end
            FRAME: begin
                if (!Ser_busy) begin
                    par_ready_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                par_ready_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        chk_done_d = Rx_valid;
        par_err_d  = Rx_valid & Par_en & (Rx_par != parity_f(Rx_Data, Par_mode));
        // Clear applies first so a same-cycle error still counts once
        cnt_base   = Err_clr ? '0 : err_cnt_q;
        err_cnt_d  = cnt_base;
        if (par_err_d && (cnt_base != {CNT_WIDTH{1'b1}})) begin
            err_cnt_d = cnt_base + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            par_bit_q   <= 1'b0;
            par_ready_q <= 1'b0;
            par_err_q   <= 1'b0;
            chk_done_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            par_bit_q   <= par_bit_d;
            par_ready_q <= par_ready_d;
            par_err_q   <= par_err_d;
            chk_done_q  <= chk_done_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign Par_bit   = par_bit_q;
    assign Par_ready = par_ready_q;
    assign Par_err   = par_err_q;
    assign Chk_done  = chk_done_q;
    assign Err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// tb/tb_uart_parity_engine.sv - directed self-checking bench for uart_parity_engine
module tb_uart_parity_engine;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Par_en;
    logic [1:0] Par_mode;
    logic       Data_valid;
    logic [7:0] P_Data;
    logic       Ser_busy;
    logic       Rx_valid;
    logic [7:0] Rx_Data;
    logic       Rx_par;
    logic       Err_clr;
    logic       Rx_valid2;
    logic       Err_clr2;

    logic       Par_bit, Par_ready, Par_err, Chk_done;
    logic [7:0] Err_cnt;
    logic       Par_bit2, Par_ready2, Par_err2, Chk_done2;
    logic [1:0] Err_cnt2;

    int checks = 0;
    int errors = 0;

    uart_parity_engine #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .Par_en(Par_en), .Par_mode(Par_mode),
        .Data_valid(Data_valid), .P_Data(P_Data), .Ser_busy(Ser_busy),
        .Par_bit(Par_bit), .Par_ready(Par_ready),
        .Rx_valid(Rx_valid), .Rx_Data(Rx_Data), .Rx_par(Rx_par),
        .Par_err(Par_err), .Chk_done(Chk_done),
        .Err_clr(Err_clr), .Err_cnt(Err_cnt)
    );

    uart_parity_engine #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut2 (
        .CLK(CLK), .RST(RST), .Par_en(Par_en), .Par_mode(Par_mode),
        .Data_valid(Data_valid), .P_Data(P_Data), .Ser_busy(Ser_busy),
        .Par_bit(Par_bit2), .Par_ready(Par_ready2),
        .Rx_valid(Rx_valid2), .Rx_Data(Rx_Data), .Rx_par(Rx_par),
        .Par_err(Par_err2), .Chk_done(Chk_done2),
        .Err_clr(Err_clr2), .Err_cnt(Err_cnt2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_tx(input string tag, input logic bit_e, input logic rdy_e);
        chk({tag, "_par_bit"}, {31'b0, Par_bit}, {31'b0, bit_e});
        chk({tag, "_par_ready"}, {31'b0, Par_ready}, {31'b0, rdy_e});
    endtask

    task automatic chk_rx(input string tag, input logic done_e, input logic err_e, input logic [7:0] cnt_e);
        chk({tag, "_chk_done"}, {31'b0, Chk_done}, {31'b0, done_e});
        chk({tag, "_par_err"}, {31'b0, Par_err}, {31'b0, err_e});
        chk({tag, "_err_cnt"}, {24'b0, Err_cnt}, {24'b0, cnt_e});
    endtask

    initial begin
        RST = 1'b0; Par_en = 1'b1; Par_mode = 2'b00; Data_valid = 1'b0; P_Data = 8'h00;
        Ser_busy = 1'b0; Rx_valid = 1'b0; Rx_Data = 8'h00; Rx_par = 1'b0; Err_clr = 1'b0;
        Rx_valid2 = 1'b0; Err_clr2 = 1'b0;
        tick; tick;
        chk_tx("reset", 1'b0, 1'b0);
        chk_rx("reset", 1'b0, 1'b0, 8'd0);
        chk("reset_cnt2", {30'b0, Err_cnt2}, 32'd0);
        RST = 1'b1;
        tick;

        // 1: even / odd parity of A5
        Data_valid = 1'b1; P_Data = 8'hA5; Par_mode = 2'b00;
        tick;
        chk_tx("t1_even", 1'b0, 1'b1);
        Par_mode = 2'b01;
        tick;
        chk_tx("t1_odd", 1'b1, 1'b1);

        // 2: load 01 odd, then frame freezes the bit
        P_Data = 8'h01; Par_mode = 2'b01;
        tick;
        chk_tx("t2_load", 1'b0, 1'b1);
        Data_valid = 1'b0; Ser_busy = 1'b1;
        tick;
        chk_tx("t2_frame", 1'b0, 1'b1);
        Data_valid = 1'b1; P_Data = 8'h03; Par_mode = 2'b10;
        tick;
        chk_tx("t2_midframe", 1'b0, 1'b1);
        Data_valid = 1'b0; Ser_busy = 1'b0;
        tick;
        chk_tx("t2_end", 1'b0, 1'b0);

        // Load and Ser_busy together in LOADED: load dropped
        Data_valid = 1'b1; P_Data = 8'h01; Par_mode = 2'b00;
        tick;
        chk_tx("t2b_load", 1'b1, 1'b1);
        P_Data = 8'h03; Ser_busy = 1'b1;
        tick;
        chk_tx("t2b_drop", 1'b1, 1'b1);
        Data_valid = 1'b0; Ser_busy = 1'b0;
        tick;
        chk_tx("t2b_end", 1'b1, 1'b0);

        // 3: RX even check of 07
        Par_mode = 2'b00; Rx_valid = 1'b1; Rx_Data = 8'h07; Rx_par = 1'b0;
        tick;
        chk_rx("t3_bad", 1'b1, 1'b1, 8'd1);
        Rx_par = 1'b1;
        tick;
        chk_rx("t3_good", 1'b1, 1'b0, 8'd1);
        Rx_valid = 1'b0;
        tick;
        chk_rx("t3_idle", 1'b0, 1'b0, 8'd1);
        Err_clr = 1'b1;
        tick;
        chk_rx("t3_clr", 1'b0, 1'b0, 8'd0);
        Err_clr = 1'b0;

        // 4: saturating 2-bit counter
        Rx_valid2 = 1'b1; Rx_par = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk($sformatf("t4_sat%0d", i), {30'b0, Err_cnt2}, (i < 3) ? i + 1 : 3);
        end
        chk("t4_err_pulse", {31'b0, Par_err2}, 32'd1);
        Err_clr2 = 1'b1;
        tick;
        chk("t4_clr_and_err", {30'b0, Err_cnt2}, 32'd1);
        Rx_valid2 = 1'b0; Err_clr2 = 1'b0;
        chk("t4_dut1_untouched", {24'b0, Err_cnt}, 32'd0);

        // 5: parity disabled
        Par_en = 1'b0; Par_mode = 2'b10; Data_valid = 1'b1; P_Data = 8'hFF;
        tick;
        chk_tx("t5_tx", 1'b0, 1'b1);
        Data_valid = 1'b0; Rx_valid = 1'b1; Rx_Data = 8'hFF; Rx_par = 1'b0;
        tick;
        chk_rx("t5_rx", 1'b1, 1'b0, 8'd0);
        Rx_valid = 1'b0;
        Ser_busy = 1'b1;
        tick;
        Ser_busy = 1'b0;
        tick;
        chk_tx("t5_idle", 1'b0, 1'b0);

        // 6: async reset mid-frame
        Par_en = 1'b1; Par_mode = 2'b10; Data_valid = 1'b1; P_Data = 8'h00;
        Rx_valid = 1'b1; Rx_Data = 8'h00; Rx_par = 1'b0;
        tick;
        chk_tx("t6_load", 1'b1, 1'b1);
        chk_rx("t6_load", 1'b1, 1'b1, 8'd1);
        Data_valid = 1'b0; Ser_busy = 1'b1;
        tick;
        chk_tx("t6_frame", 1'b1, 1'b1);
        chk_rx("t6_frame", 1'b1, 1'b1, 8'd2);
        Rx_valid = 1'b0;
        #2 RST = 1'b0;
        #1;
        chk_tx("t6_async", 1'b0, 1'b0);
        chk_rx("t6_async", 1'b0, 1'b0, 8'd0);
        tick;
        #2 RST = 1'b1;
        tick;
        chk_tx("t6_release", 1'b0, 1'b0);
        tick;
        chk_tx("t6_busy_noload", 1'b0, 1'b0);
        Ser_busy = 1'b0;
        tick;
        Ser_busy = 1'b1;
        tick;
        chk_tx("t6_busy_idle", 1'b0, 1'b0);
        Ser_busy = 1'b0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
